// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg
// Shared definitions for the accumulator command controller:
//   - 2-bit command opcodes carried on cmd_op
//   - FSM state encodings for the IDLE -> EXEC -> RESP handshake sequence
package alu_cmd_pkg;

    // Command opcodes
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
// Command-side controller for an external combinational add/sub ALU.
// Commands arrive over a valid/ready channel, are executed against a W-bit
// accumulator using the external ALU, and each resulting accumulator value is
// returned over a valid/ready response channel.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op, cmd_imm      opcode (LOAD/ADD/SUB/READ) and immediate operand
//   alu_a, alu_b, alu_op operands/op driven to the external ALU (op 1 = A-B)
//   alu_out              combinational result returned by the ALU
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             accumulator value after the command
//   rsp_zero/neg/ovf     result flags (only when ALU_CMD_FLAGS_EN is defined)
//
// Configuration macro: ALU_CMD_FLAGS_EN adds the three flag outputs.
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_imm,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_op,
    input  logic [W-1:0] alu_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
`ifdef ALU_CMD_FLAGS_EN
    output logic         rsp_zero,
    output logic         rsp_neg,
    output logic         rsp_ovf,
`endif
    output logic [W-1:0] rsp_data
);

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nx;
    logic [W-1:0]   opnd_q;
    logic [1:0]     op_q;

    // The ALU sees the accumulator and latched operand at all times; the
    // result is only captured while in EXEC.
    assign alu_a    = acc;
    assign alu_b    = opnd_q;
    assign alu_op   = (op_q == OP_SUB);
    assign rsp_data = acc;

    // Accumulator value produced by the latched command.
    always_comb begin
        acc_nx = acc;
        case (op_q)
            OP_LOAD: acc_nx = opnd_q;
            OP_ADD,
            OP_SUB:  acc_nx = alu_out;
            default: acc_nx = acc;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath registers: command latch on accept, accumulator update in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            opnd_q <= '0;
            op_q   <= OP_LOAD;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                opnd_q <= cmd_imm;
            end
            if (state == ST_EXEC) begin
                acc <= acc_nx;
            end
        end
    end

`ifdef ALU_CMD_FLAGS_EN
    logic ovf_nx;

    // Signed overflow: ADD overflows when like-signed operands give a result of
    // the other sign; SUB when unlike-signed operands give a result whose sign
    // differs from A. LOAD and READ never overflow.
    always_comb begin
        ovf_nx = 1'b0;
        case (op_q)
            OP_ADD:  ovf_nx = (acc[W-1] == opnd_q[W-1]) && (alu_out[W-1] != acc[W-1]);
            OP_SUB:  ovf_nx = (acc[W-1] != opnd_q[W-1]) && (alu_out[W-1] != acc[W-1]);
            default: ovf_nx = 1'b0;
        endcase
    end

    // Flags are captured together with the accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
            rsp_ovf  <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_zero <= (acc_nx == '0);
            rsp_neg  <= acc_nx[W-1];
            rsp_ovf  <= ovf_nx;
        end
    end
`endif

    // Next-state and handshake outputs. cmd_ready is masked during the reset
    // cycle so nothing is accepted while state is being cleared.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid) begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl
// Bench for alu_cmd_ctrl connected to a combinational add/sub ALU.
// Directed command sequences followed by randomized commands and randomized
// response back-pressure, checked against an accumulator model.
// Flag outputs are exercised when ALU_CMD_FLAGS_EN is defined.
module tb_alu_cmd_ctrl;
    import alu_cmd_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_imm;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_op;
    logic [W-1:0] alu_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
`ifdef ALU_CMD_FLAGS_EN
    logic         rsp_zero;
    logic         rsp_neg;
    logic         rsp_ovf;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] model_acc;

    always #5 clk = ~clk;

    // The combinational ALU the controller drives.
    assign alu_out = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);

    alu_cmd_ctrl #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
`ifdef ALU_CMD_FLAGS_EN
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_data  (rsp_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one command, optionally hold off the response for 'hold' cycles,
    // and check timing, data, stability and flags against the model.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] imm, input int hold);
        logic [W-1:0] exp;
        int           sa;
        int           sb;
        int           s;
        logic         ovf;
        int           waited;

        sa  = int'($signed(model_acc));
        sb  = int'($signed(imm));
        ovf = 1'b0;
        case (op)
            OP_LOAD: exp = imm;
            OP_ADD: begin
                exp = model_acc + imm;
                s   = sa + sb;
                ovf = (s > 32767) || (s < -32768);
            end
            OP_SUB: begin
                exp = model_acc - imm;
                s   = sa - sb;
                ovf = (s > 32767) || (s < -32768);
            end
            default: exp = model_acc;
        endcase

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        waited    = 0;
        while (!cmd_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_imm   = W'($urandom);
        checkOutput("exec_rsp_valid", rsp_valid, 0);
        checkOutput("exec_cmd_ready", cmd_ready, 0);
        checkOutput("exec_alu_op", alu_op, (op == OP_SUB));
        checkOutput("exec_alu_a", alu_a, model_acc);
        checkOutput("exec_alu_b", alu_b, imm);

        @(negedge clk);
        checkOutput("latency_rsp_valid", rsp_valid, 1);
        waited = 0;
        while (!rsp_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", rsp_valid, 1);
            return;
        end
        model_acc = exp;
        checkOutput("rsp_data", rsp_data, exp);
`ifdef ALU_CMD_FLAGS_EN
        checkOutput("rsp_zero", rsp_zero, (exp == 0));
        checkOutput("rsp_neg", rsp_neg, exp[W-1]);
        checkOutput("rsp_ovf", rsp_ovf, ovf);
`endif

        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = (i == hold / 2);
            cmd_op    = 2'($urandom);
            cmd_imm   = W'($urandom);
            @(negedge clk);
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_rsp_data", rsp_data, exp);
            checkOutput("hold_cmd_ready", cmd_ready, 0);
        end

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("done_rsp_valid", rsp_valid, 0);
        checkOutput("done_cmd_ready", cmd_ready, 1);
        checkOutput("done_acc", rsp_data, exp);
    endtask

    // Accept an ADD and reset the block while it is executing.
    task automatic applyResetInExec(input logic [W-1:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_imm   = imm;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("rst_exec_state", rsp_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_acc", rsp_data, 0);
        reset     = 1'b0;
        model_acc = '0;
        @(negedge clk);
        checkOutput("post_rst_cmd_ready", cmd_ready, 1);
        checkOutput("post_rst_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] rop;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_LOAD;
        cmd_imm   = '0;
        rsp_ready = 1'b0;
        model_acc = '0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_alu_a", alu_a, 0);
        checkOutput("reset_alu_b", alu_b, 0);
        checkOutput("reset_alu_op", alu_op, 0);
`ifdef ALU_CMD_FLAGS_EN
        checkOutput("reset_flags", {rsp_zero, rsp_neg, rsp_ovf}, 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        checkOutput("after_reset_cmd_ready", cmd_ready, 1);

        applyStimulus(OP_LOAD, 16'h1234, 0);
        applyStimulus(OP_LOAD, 16'h0005, 0);
        applyStimulus(OP_ADD,  16'h0003, 1);
        applyStimulus(OP_SUB,  16'h0010, 5);
        applyStimulus(OP_LOAD, 16'hFFFF, 0);
        applyStimulus(OP_ADD,  16'h0001, 0);
        applyStimulus(OP_LOAD, 16'h0000, 0);
        applyStimulus(OP_SUB,  16'h0001, 2);
        applyStimulus(OP_LOAD, 16'h7FFF, 0);
        applyStimulus(OP_ADD,  16'h0001, 0);
        applyStimulus(OP_LOAD, 16'h8000, 0);
        applyStimulus(OP_SUB,  16'h0001, 0);
        applyStimulus(OP_LOAD, 16'h1111, 0);
        applyResetInExec(16'h0002);
        applyStimulus(OP_READ, 16'h5555, 0);
        applyStimulus(OP_LOAD, 16'hABCD, 0);
        applyStimulus(OP_READ, 16'h0000, 3);
        applyStimulus(OP_ADD,  16'h0000, 0);

        for (int n = 0; n < 150; n++) begin
            rop = 2'($urandom);
            applyStimulus(rop, W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
